// File: rtl/rf_scm_pkg.sv
// rtl/rf_scm_pkg.sv - shared sizing helpers and default types for the latch register file
package rf_scm_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_N_READ     = 2;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] rf_row_t;

  function automatic int unsigned num_words(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// rtl/cluster_clock_gating.sv - glitch-free latch-based clock gate with scan override
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic clk_en_l;

  // Enable only moves while the clock is low, so clk_o never glitches.
  always_latch begin
    if (!clk_i) begin
      clk_en_l <= en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & clk_en_l;

endmodule

// File: rtl/rf_latch_row.sv
// rtl/rf_latch_row.sv - one register-file row: private gated clock plus a DATA_WIDTH latch
module rf_latch_row #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROW        = 0
) (
  input  logic                  clk,
  input  logic                  test_en_i,
  input  logic                  gate_we_i,
  input  logic [ADDR_WIDTH-1:0] gate_waddr_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam logic [ADDR_WIDTH-1:0] ROW_ADDR = ADDR_WIDTH'(ROW);

  logic                  row_en;
  logic                  row_gclk;
  logic [DATA_WIDTH-1:0] row_data;

  // The gate latches its enable in the low phase before the sampling edge,
  // so it is fed the write request that this edge will load into WeInt/WAddrInt.
  assign row_en = gate_we_i && (gate_waddr_i == ROW_ADDR);

  cluster_clock_gating u_cg (
    .clk_i     (clk),
    .en_i      (row_en),
    .test_en_i (test_en_i),
    .clk_o     (row_gclk)
  );

  // Qualifying with the sampled WeInt closes the row at once on an async reset.
  always_latch begin
    if (row_gclk && we_i && (waddr_i == ROW_ADDR)) begin
      row_data <= wdata_i;
    end
  end

  assign rdata_o = row_data;

endmodule

// File: rtl/register_file_1w_multi_port_read_vld.sv
// rtl/register_file_1w_multi_port_read_vld.sv - latch SCM register file, 1 write port, N read ports, per-row valid
module register_file_1w_multi_port_read_vld
  import rf_scm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned N_READ     = RF_N_READ
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 test_en_i,
  input  logic                                 ClearAll,
  input  logic [N_READ-1:0]                    ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]    ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]    ReadData,
  input  logic                                 WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                WriteAddr,
  input  logic [DATA_WIDTH-1:0]                WriteData
);

  localparam int unsigned NUM_WORDS = num_words(ADDR_WIDTH);

  logic                               we_int_d,    we_int_q;
  logic [ADDR_WIDTH-1:0]              waddr_int_d, waddr_int_q;
  logic [DATA_WIDTH-1:0]              wdata_int_d, wdata_int_q;
  logic [NUM_WORDS-1:0]               valid_d,     valid_q;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]  raddr_d,     raddr_q;
  logic [DATA_WIDTH-1:0]              row_data [NUM_WORDS];

  always_comb begin
    we_int_d    = WriteEnable;
    waddr_int_d = WriteEnable ? WriteAddr : waddr_int_q;
    wdata_int_d = WriteEnable ? WriteData : wdata_int_q;
    // A write in the clearing cycle keeps its own row valid.
    valid_d     = ClearAll ? '0 : valid_q;
    if (WriteEnable) begin
      valid_d[WriteAddr] = 1'b1;
    end
    raddr_d = raddr_q;
    for (int p = 0; p < N_READ; p++) begin
      if (ReadEnable[p]) begin
        raddr_d[p] = ReadAddr[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_int_q    <= 1'b0;
      waddr_int_q <= '0;
      wdata_int_q <= '0;
      valid_q     <= '0;
      raddr_q     <= '0;
    end else begin
      we_int_q    <= we_int_d;
      waddr_int_q <= waddr_int_d;
      wdata_int_q <= wdata_int_d;
      valid_q     <= valid_d;
      raddr_q     <= raddr_d;
    end
  end

  for (genvar r = 0; r < NUM_WORDS; r++) begin : g_row
    rf_latch_row #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ROW        (r)
    ) u_row (
      .clk          (clk),
      .test_en_i    (test_en_i),
      .gate_we_i    (we_int_d),
      .gate_waddr_i (waddr_int_d),
      .we_i         (we_int_q),
      .waddr_i      (waddr_int_q),
      .wdata_i      (wdata_int_q),
      .rdata_o      (row_data[r])
    );
  end

  always_comb begin
    ReadData = '0;
    for (int p = 0; p < N_READ; p++) begin
      if (valid_q[raddr_q[p]]) begin
        ReadData[p] = row_data[raddr_q[p]];
      end
    end
  end

endmodule
